// File: rtl/panda_pkg.sv
// Shared types for the panda memory-port arbiter.
package panda_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT_GNT,
    ARB_WAIT_RSP
  } arb_state_e;

  typedef enum logic {
    OWNER_INSTR,
    OWNER_DATA
  } arb_owner_e;

  localparam logic [3:0] FETCH_BE = 4'b1111;

endpackage

// File: rtl/panda_mem_arbiter.sv
// Shares one single-outstanding req/gnt/rvalid memory port between instruction fetch and LSU.
// Data has priority; a streak counter guarantees fetch a grant after DATA_BURST_MAX data grants.
module panda_mem_arbiter #(
  parameter int unsigned DATA_BURST_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  input  logic        instr_kill_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  import panda_pkg::*;

  localparam int unsigned StreakW = $clog2(DATA_BURST_MAX + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(DATA_BURST_MAX);

  arb_state_e           state_q, state_d;
  arb_owner_e           owner_q, owner_d;
  logic [StreakW-1:0]   streak_q, streak_d;
  logic                 kill_pend_q, kill_pend_d;

  arb_owner_e idle_owner, cur_owner;
  logic       any_req, issue, granted, rsp;

  always_comb begin
    any_req    = instr_req_i | data_req_i;
    // Data wins unless fetch has waited through a full burst of data grants.
    idle_owner = (data_req_i && !(instr_req_i && (streak_q == StreakMax))) ? OWNER_DATA
                                                                           : OWNER_INSTR;
    cur_owner  = (state_q == ARB_IDLE) ? idle_owner : owner_q;
    issue      = !rst_i && (((state_q == ARB_IDLE) && any_req) || (state_q == ARB_WAIT_GNT));
    granted    = issue && mem_gnt_i;
    rsp        = !rst_i && (state_q == ARB_WAIT_RSP) && mem_rvalid_i;
  end

  always_comb begin
    mem_req_o   = issue;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'b0000;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (issue) begin
      if (cur_owner == OWNER_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = FETCH_BE;
        mem_addr_o  = instr_addr_i;
      end
    end

    instr_gnt_o    = granted && (cur_owner == OWNER_INSTR);
    data_gnt_o     = granted && (cur_owner == OWNER_DATA);
    data_rvalid_o  = rsp && (owner_q == OWNER_DATA);
    instr_rvalid_o = rsp && (owner_q == OWNER_INSTR) && !kill_pend_q && !instr_kill_i;
    instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
    data_rdata_o   = data_rvalid_o ? mem_rdata_i : 32'h0;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    kill_pend_d = kill_pend_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          owner_d = idle_owner;
          state_d = mem_gnt_i ? ARB_WAIT_RSP : ARB_WAIT_GNT;
        end
      end
      ARB_WAIT_GNT: if (mem_gnt_i) state_d = ARB_WAIT_RSP;
      ARB_WAIT_RSP: if (mem_rvalid_i) state_d = ARB_IDLE;
      default:      state_d = ARB_IDLE;
    endcase

    // A flush only taints a fetch that is already locked onto the bus.
    if ((state_q != ARB_IDLE) && (owner_q == OWNER_INSTR) && instr_kill_i) begin
      kill_pend_d = 1'b1;
    end
    if (state_d == ARB_IDLE) kill_pend_d = 1'b0;

    if (granted) begin
      if ((cur_owner == OWNER_DATA) && instr_req_i) begin
        streak_d = (streak_q == StreakMax) ? streak_q : streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWNER_DATA;
      streak_q    <= '0;
      kill_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      kill_pend_q <= kill_pend_d;
    end
  end

endmodule

// File: tb/tb_panda_mem_arbiter.sv
// Self-checking bench for panda_mem_arbiter: directed scenarios then randomized traffic,
// all compared against a transaction-level reference model.
module tb_panda_mem_arbiter;

  localparam int unsigned Max = 4;

  logic        clk = 1'b0;
  logic        rst, ireq, ikill, dreq, dwe, mgnt, mrvalid;
  logic [31:0] iaddr, daddr, dwdata, mrdata;
  logic [3:0]  dbe;
  logic        instr_gnt, instr_rvalid, data_gnt, data_rvalid;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] instr_rdata, data_rdata, mem_addr, mem_wdata;

  panda_mem_arbiter #(.DATA_BURST_MAX(Max)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_req_i    (ireq),
    .instr_addr_i   (iaddr),
    .instr_kill_i   (ikill),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_rdata_o  (instr_rdata),
    .data_req_i     (dreq),
    .data_we_i      (dwe),
    .data_be_i      (dbe),
    .data_addr_i    (daddr),
    .data_wdata_i   (dwdata),
    .data_gnt_o     (data_gnt),
    .data_rvalid_o  (data_rvalid),
    .data_rdata_o   (data_rdata),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_be_o       (mem_be),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_gnt_i      (mgnt),
    .mem_rvalid_i   (mrvalid),
    .mem_rdata_i    (mrdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Requesters must hold req until granted (outside reset).
  logic ipend = 1'b0, dpend = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      ipend <= 1'b0;
      dpend <= 1'b0;
    end else begin
      assert (!(ipend && !ireq)) else $error("instr req dropped before grant");
      assert (!(dpend && !dreq)) else $error("data req dropped before grant");
      ipend <= ireq && !instr_gnt;
      dpend <= dreq && !data_gnt;
    end
  end

  // Reference model: lock 0=free, 1=fetch, 2=data; issued=granted and awaiting response.
  int m_lock = 0, m_streak = 0;
  bit m_issued = 0, m_killed = 0;
  bit e_igrant, e_dgrant;
  logic        s_req, s_we, s_igrant, s_dgrant, s_irv, s_drv;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_ird;

  // Called at posedge+1 with inputs set; samples at the falling edge, advances one cycle.
  task automatic step();
    int own;
    bit ereq, egnt, ersp, eirv, edrv;
    #4;
    {s_req, s_we, s_be, s_addr} = {mem_req, mem_we, mem_be, mem_addr};
    {s_igrant, s_dgrant, s_irv, s_drv, s_ird} =
        {instr_gnt, data_gnt, instr_rvalid, data_rvalid, instr_rdata};
    own = 0; ereq = 0; egnt = 0; ersp = 0;
    if (!rst) begin
      if (m_lock == 0) begin
        if (dreq && !(ireq && m_streak == Max)) own = 2;
        else if (ireq) own = 1;
        ereq = (own != 0);
      end else begin
        own  = m_lock;
        ereq = !m_issued;
      end
      egnt = ereq && mgnt;
      ersp = m_issued && mrvalid;
    end
    eirv = ersp && own == 1 && !m_killed && !ikill;
    edrv = ersp && own == 2;
    e_igrant = egnt && own == 1;
    e_dgrant = egnt && own == 2;
    check("mem_req", mem_req, ereq);
    check("instr_gnt", instr_gnt, e_igrant);
    check("data_gnt", data_gnt, e_dgrant);
    check("instr_rvalid", instr_rvalid, eirv);
    check("data_rvalid", data_rvalid, edrv);
    check("instr_rdata", instr_rdata, eirv ? mrdata : 32'h0);
    check("data_rdata", data_rdata, edrv ? mrdata : 32'h0);
    if (ereq) begin
      check("mem_we", mem_we, own == 2 ? dwe : 1'b0);
      check("mem_be", mem_be, own == 2 ? dbe : 4'hF);
      check("mem_addr", mem_addr, own == 2 ? daddr : iaddr);
      check("mem_wdata", mem_wdata, own == 2 ? dwdata : 32'h0);
    end else if (rst || m_lock == 0) begin
      check("idle_bus", {mem_we, mem_be, mem_addr[26:0]}, 32'h0);
      check("idle_wdata", mem_wdata, 32'h0);
    end
    if (rst) begin
      m_lock = 0; m_issued = 0; m_streak = 0; m_killed = 0;
    end else begin
      if (m_lock == 1 && ikill) m_killed = 1;
      if (egnt) begin
        m_streak = (own == 2 && ireq) ? ((m_streak < Max) ? m_streak + 1 : Max) : 0;
        m_issued = 1;
      end
      if (ereq) m_lock = own;
      if (ersp) begin
        m_lock = 0; m_issued = 0; m_killed = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  bit exp_order[8] = '{1, 1, 1, 1, 0, 1, 1, 1};
  bit got_order[8];
  int ngrant;
  bit rsp_wait;
  int rsp_cnt;

  initial begin
    {rst, ireq, ikill, dreq, dwe, mgnt, mrvalid} = 7'b1000000;
    {iaddr, daddr, dwdata, mrdata, dbe} = '0;
    @(posedge clk); #1;
    step(); step();
    rst = 0;

    // Fetch alone, granted at once, response two cycles later.
    ireq = 1; iaddr = 32'h100; mgnt = 1;
    step(); check("t1_gnt", s_igrant, 1);
    ireq = 0; mgnt = 0;
    step();
    mrvalid = 1; mrdata = 32'h13;
    step();
    check("t1_rvalid", s_irv, 1); check("t1_rdata", s_ird, 32'h13); check("t1_drv", s_drv, 0);
    mrvalid = 0;

    // Both request: data store wins.
    ireq = 1; iaddr = 32'h200;
    dreq = 1; dwe = 1; dbe = 4'b0011; daddr = 32'h2000; dwdata = 32'hCAFE; mgnt = 1;
    step();
    check("t2_dgnt", s_dgrant, 1); check("t2_igrant", s_igrant, 0);
    check("t2_we", s_we, 1); check("t2_be", s_be, 4'b0011);
    dreq = 0; mgnt = 0;
    step();
    mrvalid = 1; step(); check("t2_drv", s_drv, 1);
    mrvalid = 0; mgnt = 1;
    step(); check("t2_ignt", s_igrant, 1);
    ireq = 0; mgnt = 0; mrvalid = 1;
    step(); mrvalid = 0;

    // Decision frozen while memory stalls the fetch.
    ireq = 1; iaddr = 32'h300; dwe = 0; dbe = 4'hF; daddr = 32'h4000;
    step();
    dreq = 1;
    step(); step();
    check("t4_addr", s_addr, 32'h300); check("t4_dgnt", s_dgrant, 0);
    mgnt = 1;
    step(); check("t4_ignt", s_igrant, 1);
    ireq = 0;
    step(); check("t4_noreq", s_req, 0);
    mrvalid = 1; step(); check("t4_irv", s_irv, 1); check("t4_dwait", s_dgrant, 0);
    mrvalid = 0;
    step(); check("t4_dgnt_late", s_dgrant, 1);
    dreq = 0; mgnt = 0; mrvalid = 1;
    step(); mrvalid = 0;

    // Kill during the response wait suppresses fetch rvalid.
    ireq = 1; iaddr = 32'h400; mgnt = 1;
    step();
    ireq = 0; mgnt = 0; ikill = 1;
    step();
    ikill = 0; mrvalid = 1; mrdata = 32'hDEAD;
    step(); check("t5_killed", s_irv, 0);
    mrvalid = 0; dreq = 1; daddr = 32'h500; mgnt = 1;
    step(); check("t5_dgnt", s_dgrant, 1);
    dreq = 0; mgnt = 0; mrvalid = 1;
    step(); check("t5_drv", s_drv, 1);
    mrvalid = 0;

    // Reset mid-transaction (with a nonzero streak), stale response afterwards.
    ireq = 1; dreq = 1; mgnt = 1;
    step();
    ireq = 0; dreq = 0; mgnt = 0; rst = 1;
    step();
    rst = 0; mrvalid = 1;
    step();
    check("t6_drv", s_drv, 0); check("t6_irv", s_irv, 0); check("t6_req", s_req, 0);
    mrvalid = 0;

    // Continuous contention: D,D,D,D,I,D,D,D.
    ireq = 1; dreq = 1; mgnt = 1; ngrant = 0;
    for (int c = 0; c < 40 && ngrant < 8; c++) begin
      mrvalid = m_issued;
      step();
      if (s_igrant || s_dgrant) begin
        got_order[ngrant] = s_dgrant;
        ngrant++;
      end
    end
    check("burst_cnt", ngrant, 8);
    for (int i = 0; i < 8; i++) check($sformatf("burst_%0d", i), got_order[i], exp_order[i]);
    for (int c = 0; c < 20 && (ireq || dreq || m_lock != 0); c++) begin
      mrvalid = m_issued;
      step();
      if (e_igrant) ireq = 0;
      if (e_dgrant) dreq = 0;
    end
    mrvalid = 0; mgnt = 0;

    // Randomized traffic with random stalls, latencies, kills, stray responses and resets.
    rsp_wait = 0; rsp_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 300 == 0);
      if (rst) begin
        ireq = 0; dreq = 0;
      end else begin
        if (!ireq && $urandom % 3 == 0) begin
          ireq = 1; iaddr = $urandom & 32'hFFFF_FFFC;
        end
        if (!dreq && $urandom % 3 == 0) begin
          dreq = 1; dwe = $urandom; dbe = $urandom; daddr = $urandom; dwdata = $urandom;
        end
      end
      ikill  = ($urandom % 8 == 0);
      mgnt   = $urandom;
      mrdata = $urandom;
      mrvalid = rsp_wait ? (rsp_cnt == 0) : ($urandom % 16 == 0);
      step();
      if (e_igrant) ireq = 0;
      if (e_dgrant) dreq = 0;
      if (rst) rsp_wait = 0;
      else if (rsp_wait && mrvalid) rsp_wait = 0;
      else if (rsp_wait) rsp_cnt--;
      if (e_igrant || e_dgrant) begin
        rsp_wait = 1;
        rsp_cnt  = $urandom_range(0, 2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
